// File: rtl/md5_msg_pad.sv
// md5_msg_pad: packs a byte stream into 512-bit MD5 blocks and pads the
// final block (0x80, zero fill, 64-bit bit length).
// Ports: clk_i/rst_i (async, active-high); byte_i, byte_valid_i,
//   byte_last_i, empty_i, byte_ready_o: byte-beat input handshake;
//   blk_o[0:15], blk_valid_o, blk_ready_i, blk_first_o, blk_last_o:
//   block output handshake.
// Option: define MD5_PAD_WORD_BE_EN for MSB-first byte packing and
//   high-word-first length placement.
// LEN_W must be in 1..60.
module md5_msg_pad #(
  parameter int LEN_W = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        byte_last_i,
  input  logic        empty_i,
  output logic        byte_ready_o,
  output logic [31:0] blk_o [0:15],
  output logic        blk_valid_o,
  input  logic        blk_ready_i,
  output logic        blk_first_o,
  output logic        blk_last_o
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_LEN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]       r_state;
  logic [5:0]       r_idx;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_blk [0:15];
  logic             r_first;
  logic             r_last;
  logic             r_pad_pend;
  logic             r_len_pend;

  logic        w_beat;
  logic        w_data;
  logic        w_xfer;
  logic [3:0]  w_wi;
  logic [4:0]  w_sh;
  logic [63:0] w_bitlen;
  logic [31:0] w_w14;
  logic [31:0] w_w15;

  // Gated by rst_i so ready stays low while reset is held.
  assign byte_ready_o = (r_state == S_FILL) & ~rst_i;
  assign blk_valid_o  = (r_state == S_OUT);
  assign blk_first_o  = r_first;
  assign blk_last_o   = r_last;
  assign blk_o        = r_blk;

  assign w_beat = byte_valid_i & byte_ready_o;
  // An empty last beat only closes the message.
  assign w_data = w_beat & ~(byte_last_i & empty_i);
  assign w_xfer = blk_valid_o & blk_ready_i;

  assign w_wi     = r_idx[5:2];
  assign w_bitlen = {{(61-LEN_W){1'b0}}, r_cnt, 3'b000};

`ifdef MD5_PAD_WORD_BE_EN
  assign w_sh  = {~r_idx[1:0], 3'b000};
  assign w_w14 = w_bitlen[63:32];
  assign w_w15 = w_bitlen[31:0];
`else
  assign w_sh  = {r_idx[1:0], 3'b000};
  assign w_w14 = w_bitlen[31:0];
  assign w_w15 = w_bitlen[63:32];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_FILL;
      r_idx      <= 6'd0;
      r_cnt      <= '0;
      r_first    <= 1'b1;
      r_last     <= 1'b0;
      r_pad_pend <= 1'b0;
      r_len_pend <= 1'b0;
      for (int i = 0; i < 16; i++) r_blk[i] <= '0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (w_beat) begin
            if (w_data) begin
              r_blk[w_wi][w_sh +: 8] <= byte_i;
              r_idx <= r_idx + 6'd1;
              r_cnt <= r_cnt + LEN_W'(1);
            end
            if (byte_last_i) begin
              // Block already full: ship it, pad next.
              if (w_data && r_idx == 6'd63) begin
                r_state    <= S_OUT;
                r_pad_pend <= 1'b1;
              end else begin
                r_state <= S_PAD;
              end
            end else if (r_idx == 6'd63) begin
              r_state <= S_OUT;
            end
          end
        end
        S_PAD: begin
          r_blk[w_wi][w_sh +: 8] <= 8'h80;
          r_pad_pend <= 1'b0;
          // No room for the length: it goes in an extra block.
          if (r_idx <= 6'd55) begin
            r_state <= S_LEN;
          end else begin
            r_state    <= S_OUT;
            r_len_pend <= 1'b1;
          end
        end
        S_LEN: begin
          r_blk[14]  <= w_w14;
          r_blk[15]  <= w_w15;
          r_last     <= 1'b1;
          r_len_pend <= 1'b0;
          r_state    <= S_OUT;
        end
        S_OUT: begin
          if (w_xfer) begin
            for (int i = 0; i < 16; i++) r_blk[i] <= '0;
            r_idx   <= 6'd0;
            r_first <= r_last;
            r_last  <= 1'b0;
            if (r_last) r_cnt <= '0;
            if (r_pad_pend)      r_state <= S_PAD;
            else if (r_len_pend) r_state <= S_LEN;
            else                 r_state <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_pad.sv
// tb_md5_msg_pad: table vectors, hand sequences and random messages
// checked against a padded-byte-stream model of MD5 block preparation.
module tb_md5_msg_pad;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [511:0] d;
    logic         first;
    logic         last;
  } blk_t;

  typedef struct {
    string       nm;
    int          n;
    bit          abc;
    bit          stall;
    int          nblk;
    int          b0;
    int          w0;
    logic [31:0] v0;
    int          b1;
    int          w1;
    logic [31:0] v1;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_last_i = 1'b0;
  logic        empty_i = 1'b0;
  logic        byte_ready_o;
  logic [31:0] blk_o [0:15];
  logic        blk_valid_o;
  logic        blk_ready_i;
  logic        blk_first_o;
  logic        blk_last_o;

  int n_vec = 0;
  int n_bad = 0;
  int rmode = 0;
  int scnt  = 0;

  blk_t         exp_q[$];
  blk_t         got_q[$];
  logic [511:0] last_got [0:3];
  logic [511:0] m_d;
  logic [513:0] held;
  bit           stalled = 0;

  md5_msg_pad #(.LEN_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_last_i  (byte_last_i),
    .empty_i      (empty_i),
    .byte_ready_o (byte_ready_o),
    .blk_o        (blk_o),
    .blk_valid_o  (blk_valid_o),
    .blk_ready_i  (blk_ready_i),
    .blk_first_o  (blk_first_o),
    .blk_last_o   (blk_last_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [519:0] act,
                     input logic [519:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected blocks straight from the padding rule.
  function automatic void model(input bq_t msg);
    int          L;
    int          tot;
    logic [63:0] bl;
    bq_t         p;
    blk_t        e;
    L   = msg.size();
    tot = ((L + 8) / 64 + 1) * 64;
    bl  = 64'(L) * 64'd8;
    p   = msg;
    p.push_back(8'h80);
    while (p.size() < tot) p.push_back(8'h00);
    for (int b = 0; b < tot / 64; b++) begin
      e.d = '0;
      for (int n = 0; n < 64; n++) begin
`ifdef MD5_PAD_WORD_BE_EN
        e.d[32*(n/4) + 24 - 8*(n%4) +: 8] = p[64*b + n];
`else
        e.d[32*(n/4) + 8*(n%4) +: 8] = p[64*b + n];
`endif
      end
      e.first = (b == 0);
      e.last  = (b == tot / 64 - 1);
      if (e.last) begin
`ifdef MD5_PAD_WORD_BE_EN
        e.d[32*14 +: 32] = bl[63:32];
        e.d[32*15 +: 32] = bl[31:0];
`else
        e.d[32*14 +: 32] = bl[31:0];
        e.d[32*15 +: 32] = bl[63:32];
`endif
      end
      exp_q.push_back(e);
    end
  endfunction

  // Block ready generator: 0 always, 1 random, 2 stall 5 cycles.
  initial begin
    blk_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (rmode)
        0: blk_ready_i = 1'b1;
        1: blk_ready_i = 1'($urandom_range(0, 1));
        default: begin
          if (blk_valid_o && scnt < 5) begin
            blk_ready_i = 1'b0;
            scnt++;
          end else begin
            blk_ready_i = 1'b1;
            scnt = 0;
          end
        end
      endcase
    end
  end

  // Block monitor with handshake stability checks.
  always @(negedge clk_i) begin
    for (int k = 0; k < 16; k++) m_d[32*k +: 32] = blk_o[k];
    if (!rst_i) begin
      if (blk_valid_o) chk("ready_in_out", 520'(byte_ready_o), 520'(0));
      if (stalled) begin
        chk("valid_held", 520'(blk_valid_o), 520'(1));
        chk("stall_stable", 520'({m_d, blk_first_o, blk_last_o}),
            520'(held));
      end
      stalled = blk_valid_o && !blk_ready_i;
      held    = {m_d, blk_first_o, blk_last_o};
      if (blk_valid_o && blk_ready_i)
        got_q.push_back('{m_d, blk_first_o, blk_last_o});
    end else begin
      stalled = 0;
    end
  end

  task automatic beat(input logic [7:0] b, input logic l, input logic e);
    int n = 0;
    byte_i       = b;
    byte_last_i  = l;
    empty_i      = e;
    byte_valid_i = 1'b1;
    @(negedge clk_i);
    while (!byte_ready_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 2000) chk("beat_timeout", 520'(n), 520'(0));
    @(posedge clk_i);
    #1;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    empty_i      = 1'b0;
  endtask

  task automatic drive_msg(input bq_t msg, input bit empty_end,
                           input bit gaps);
    bit ee;
    ee = empty_end || (msg.size() == 0);
    model(msg);
    foreach (msg[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
      beat(msg[i], (i == msg.size() - 1) && !ee, 1'b0);
    end
    if (ee) beat(8'($urandom), 1'b1, 1'b1);
  endtask

  task automatic drain(input string nm, output int k);
    int   n = 0;
    blk_t e;
    blk_t g;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    repeat (4) @(posedge clk_i);
    #1;
    chk({nm, "_count"}, 520'(got_q.size()), 520'(exp_q.size()));
    k = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk($sformatf("%s_blk%0d", nm, k), 520'(g.d), 520'(e.d));
      chk($sformatf("%s_flags%0d", nm, k), 520'({g.first, g.last}),
          520'({e.first, e.last}));
      if (k < 4) last_got[k] = g.d;
      k++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_reset();
    logic [511:0] d;
    rst_i        = 1'b1;
    byte_valid_i = 1'b0;
    byte_last_i  = 1'b0;
    empty_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = blk_o[k];
    chk("rst_outs", 520'({byte_ready_o, blk_valid_o, blk_first_o,
        blk_last_o}), 520'(4'b0010));
    chk("rst_blk", 520'(d), 520'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_rst", 520'(byte_ready_o), 520'(1));
    @(posedge clk_i);
    #1;
  endtask

  function automatic bq_t mk(input int n, input bit abc);
    bq_t q;
    if (abc) begin
      q.push_back(8'h61);
      q.push_back(8'h62);
      q.push_back(8'h63);
    end else begin
      for (int i = 0; i < n; i++) q.push_back(8'h00);
    end
    return q;
  endfunction

  vec_t tbl [0:4];

  initial begin
    bq_t msg;
    int  k;
    int  lat;
    int  len;

    tbl[0] = '{"empty", 0, 0, 0, 1, 0, 0, 32'h00000080,
               0, 14, 32'h0};
    tbl[1] = '{"abc", 3, 1, 0, 1, 0, 0, 32'h80636261,
               0, 14, 32'h00000018};
    tbl[2] = '{"z55", 55, 0, 0, 1, 0, 13, 32'h80000000,
               0, 14, 32'h000001B8};
    tbl[3] = '{"z56", 56, 0, 0, 2, 0, 14, 32'h00000080,
               1, 14, 32'h000001C0};
    tbl[4] = '{"z64stall", 64, 0, 1, 2, 1, 0, 32'h00000080,
               1, 14, 32'h00000200};

    do_reset();

    for (int t = 0; t < 5; t++) begin
      rmode = tbl[t].stall ? 2 : 0;
      msg = mk(tbl[t].n, tbl[t].abc);
      drive_msg(msg, tbl[t].n == 0, 1'b0);
      drain(tbl[t].nm, k);
      chk({tbl[t].nm, "_nblk"}, 520'(k), 520'(tbl[t].nblk));
`ifndef MD5_PAD_WORD_BE_EN
      chk({tbl[t].nm, "_spot0"},
          520'(last_got[tbl[t].b0][32*tbl[t].w0 +: 32]),
          520'(tbl[t].v0));
      chk({tbl[t].nm, "_spot1"},
          520'(last_got[tbl[t].b1][32*tbl[t].w1 +: 32]),
          520'(tbl[t].v1));
`endif
    end
    rmode = 0;

    // Empty message: valid three cycles after the beat.
    msg.delete();
    model(msg);
    beat(8'h00, 1'b1, 1'b1);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!blk_valid_o && lat < 20);
    chk("empty_latency", 520'(lat), 520'(3));
    @(posedge clk_i);
    #1;
    drain("empty_lat", k);

    // Full non-last block: valid the cycle after byte 64.
    msg = mk(64, 1'b0);
    model(msg);
    for (int i = 0; i < 64; i++) beat(8'h00, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("full_latency", 520'(blk_valid_o), 520'(1));
    @(posedge clk_i);
    #1;
    beat(8'h00, 1'b1, 1'b1);
    drain("full_lat", k);

    // Reset mid-message discards it.
    for (int i = 0; i < 30; i++) beat(8'($urandom), 1'b0, 1'b0);
    do_reset();
    repeat (6) @(posedge clk_i);
    #1;
    chk("abort_no_blk", 520'(got_q.size()), 520'(0));
    msg = mk(3, 1'b1);
    drive_msg(msg, 1'b0, 1'b0);
    drain("abort_abc", k);
`ifndef MD5_PAD_WORD_BE_EN
    chk("abort_abc_w0", 520'(last_got[0][31:0]), 520'(32'h80636261));
`endif

    // Random messages, random gaps and back-pressure.
    rmode = 1;
    for (int r = 0; r < 25; r++) begin
      msg.delete();
      len = $urandom_range(0, 140);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      drive_msg(msg, $urandom_range(0, 3) == 0, 1'b1);
      drain($sformatf("rnd%0d", r), k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
